apu_voice_mixer: RTL and testbench
==================================

# apu_voice_mixer

Multi-channel sound-effect engine, the parametrised successor to the single-oscillator PWM sawtooth generator. Each of `NUM_CH` voices is started by a game-event pulse (sheep/sword/player–dragon collision, etc.). A voice runs a phase-accumulator oscillator with a per-voice waveform and a linear decay envelope. The voices are summed and converted by a glitch-free PWM stage into the 1-bit `sound` pin.

## Interface
Parameters:
- `NUM_CH`, default 3: number of voices, range 1–8.
- `PHASE_BITS`, default 8: phase accumulator, sample and period width.
- `VOL_BITS`, default 4: envelope volume width; `VMAX = 2**VOL_BITS-1`.
- `TICK_DIV`, default 65536: clk cycles per envelope tick; must be ≥2.
- Derived: `MIX_BITS = PHASE_BITS + $clog2(NUM_CH)`. This is the mixer and PWM counter width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `trig` in `NUM_CH`: per-voice event. The rising edge starts or restarts the voice.
- `cfg_period` in `NUM_CH*PHASE_BITS`: per-voice phase increment. Voice k uses slice `[k*PHASE_BITS +: PHASE_BITS]`.
- `cfg_wave` in `NUM_CH`: per-voice waveform, 0 = saw, 1 = square.
- `busy` out `NUM_CH`: voice k is in PLAY.
- `sound` out 1: registered PWM output.

## Operation
- Tick divider: free-running counter 0..`TICK_DIV-1`. `tick` is asserted for one cycle when the count equals `TICK_DIV-1`. The counter then wraps to 0.
- Edge detect: `trig_d` register per voice. `start[k] = trig[k] & ~trig_d[k]`.
- Voice FSM has two states, IDLE and PLAY:
  - `start` in any state: go to PLAY. Set `vol<=VMAX` and `phase<=0`, and latch the period and wave for that voice. A retrigger during PLAY restarts the voice.
  - PLAY, no `start`: `phase <= phase + period_q`, wrapping modulo `2**PHASE_BITS`.
  - PLAY with `tick`: `vol <= vol-1`.
  - PLAY, `tick` and `vol==1`: set `vol<=0` and go to IDLE.
  - `start` and `tick` in the same cycle: `start` wins and the tick is ignored for that voice.
  - IDLE: `phase` and `vol` hold at 0.
- Sample generation:
  - Saw sample = `phase`.
  - Square sample = all-ones when `phase[MSB]` is 1, else 0.
- Amplitude `amp = (sample*vol) >> VOL_BITS`.
  - The product is `PHASE_BITS+VOL_BITS` wide; `amp` is `PHASE_BITS` wide.
  - `amp` is 0 in IDLE.
- Mixer: `mix = Σ amp[k]`, computed `MIX_BITS` wide with no saturation. Overflow cannot occur by construction.
- PWM stage:
  - `pwm_cnt` is a `MIX_BITS`-wide free-running counter.
  - `mix_q <= mix` only in the cycle where `pwm_cnt` is all-ones. The duty cycle therefore changes only at PWM period boundaries.
  - `sound <= (pwm_cnt < mix_q)`.
- `period_q = 0` is legal. Phase stays 0, the voice is silent, and `busy` behaves normally.

## Timing
- Reset values: `busy=0`, `sound=0`, all `phase`/`vol`/`trig_d`/`mix_q`/`pwm_cnt`/tick counter = 0, all voices IDLE.
- A reset asserted mid-play forces the reset state on the next edge. Reset takes priority over `start`.
- Start latency: `trig` rises in the cycle before edge n. After edge n, `busy=1` and `vol=VMAX`. `phase` first advances at edge n+1.
- `trig` held high does not retrigger. A new start needs `trig` low for at least one cycle.
- Voice duration: `VMAX` ticks. `busy` stays high for between `(VMAX-1)*TICK_DIV+1` and `VMAX*TICK_DIV` cycles.
- Mix-to-sound latency: `mix_q` is updated at the end of a PWM period. `sound` reflects `mix_q` one cycle after each `pwm_cnt` value.
- PWM period is `2**MIX_BITS` cycles. `mix_q=0` gives a constant 0 on `sound`.

## Structure
- Package `apu_pkg`:
  - `voice_state_t` enum {IDLE, PLAY}.
  - `WAVE_SAW`/`WAVE_SQUARE` constants.
  - `vmax(VOL_BITS)` function.
- Sub-module `apu_voice`:
  - Contains one voice: edge detect, FSM, phase accumulator, sample select and envelope multiply.
  - Inputs: `tick`, config slice, `trig` bit.
  - Outputs: `amp`, `busy`.
  - Instantiated `NUM_CH` times in a generate loop.
- Top level holds the tick divider, adder tree, `mix_q` and the PWM stage.

## Test plan
Parameters for all scenarios: `NUM_CH=3`, `PHASE_BITS=8`, `VOL_BITS=4`, `TICK_DIV=16`. `MIX_BITS` is therefore 10.

- **Reset:** hold `reset` 3 cycles with random inputs → `busy=000` and `sound=0`. After release with no triggers, `sound` stays 0 for 2048 cycles.
- **Single saw voice:** voice 0 with period 1, saw, one-cycle `trig` pulse → `busy[0]` rises at the next edge and `phase` counts 0,1,2,…. `busy[0]` falls after 225–240 cycles. In the first full PWM period, the number of high `sound` cycles equals `mix_q`.
- **Square, full scale:** voice 1 with period 128, square → sample alternates 255/0 each cycle. `amp` at `VMAX` is 239 and decreases by 15 or 16 per tick.
- **Retrigger:** pulse `trig[0]`, wait until `vol=5`, pulse again → `vol` returns to 15 and `phase` returns to 0 at the next edge. `busy[0]` never drops.
- **Start/tick collision:** assert the `trig` edge in the same cycle that `tick` fires → `vol=15` afterwards, not 14.
- **Three voices:** all saw with periods 1/2/3, triggered together → `mix` never exceeds 1023. `mix_q` changes only in cycles where `pwm_cnt=1023`. The held-high `trig` causes no restart.

Source files
------------

// File: rtl/apu_pkg.sv
// rtl/apu_pkg.sv - shared types and constants for the voice mixer
package apu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } voice_state_t;

  localparam logic WAVE_SAW    = 1'b0;
  localparam logic WAVE_SQUARE = 1'b1;

  function automatic int unsigned vmax(input int unsigned vol_bits);
    return (32'd1 << vol_bits) - 32'd1;
  endfunction

endpackage

// File: rtl/apu_voice.sv
// rtl/apu_voice.sv - one voice: trigger edge detect, IDLE/PLAY FSM,
// phase accumulator, waveform select and linear decay envelope
module apu_voice
  import apu_pkg::*;
#(
  parameter int PHASE_BITS = 8,
  parameter int VOL_BITS   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick_i,
  input  logic                  trig_i,
  input  logic [PHASE_BITS-1:0] period_i,
  input  logic                  wave_i,
  output logic [PHASE_BITS-1:0] amp_o,
  output logic                  busy_o
);

  localparam logic [VOL_BITS-1:0] VMAX = VOL_BITS'(vmax(VOL_BITS));
  localparam int PROD_BITS = PHASE_BITS + VOL_BITS;

  voice_state_t          state_q, state_d;
  logic                  trig_q;
  logic [VOL_BITS-1:0]   vol_q, vol_d;
  logic [PHASE_BITS-1:0] phase_q, phase_d;
  logic [PHASE_BITS-1:0] period_q, period_d;
  logic                  wave_q, wave_d;
  logic                  start;
  logic [PHASE_BITS-1:0] sample;
  logic [PROD_BITS-1:0]  prod;

  assign start = trig_i & ~trig_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      trig_q   <= 1'b0;
      vol_q    <= '0;
      phase_q  <= '0;
      period_q <= '0;
      wave_q   <= WAVE_SAW;
    end else begin
      state_q  <= state_d;
      trig_q   <= trig_i;
      vol_q    <= vol_d;
      phase_q  <= phase_d;
      period_q <= period_d;
      wave_q   <= wave_d;
    end
  end

  // A start always wins over a coincident envelope tick.
  always_comb begin
    state_d  = state_q;
    vol_d    = vol_q;
    phase_d  = phase_q;
    period_d = period_q;
    wave_d   = wave_q;
    if (start) begin
      state_d  = PLAY;
      vol_d    = VMAX;
      phase_d  = '0;
      period_d = period_i;
      wave_d   = wave_i;
    end else if (state_q == PLAY) begin
      phase_d = phase_q + period_q;
      if (tick_i) begin
        if (vol_q == VOL_BITS'(1)) begin
          state_d = IDLE;
          vol_d   = '0;
          phase_d = '0;
        end else begin
          vol_d = vol_q - VOL_BITS'(1);
        end
      end
    end else begin
      vol_d   = '0;
      phase_d = '0;
    end
  end

  assign sample = (wave_q == WAVE_SQUARE) ? {PHASE_BITS{phase_q[PHASE_BITS-1]}} : phase_q;
  assign prod   = {{VOL_BITS{1'b0}}, sample} * {{PHASE_BITS{1'b0}}, vol_q};
  assign amp_o  = (state_q == PLAY) ? PHASE_BITS'(prod >> VOL_BITS) : '0;
  assign busy_o = (state_q == PLAY);

endmodule

// File: rtl/apu_voice_mixer.sv
// rtl/apu_voice_mixer.sv - multi-voice sound engine: envelope tick divider,
// voice array, adder tree and period-synchronous PWM output
module apu_voice_mixer
  import apu_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int PHASE_BITS = 8,
  parameter int VOL_BITS   = 4,
  parameter int TICK_DIV   = 65536
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            trig,
  input  logic [NUM_CH*PHASE_BITS-1:0] cfg_period,
  input  logic [NUM_CH-1:0]            cfg_wave,
  output logic [NUM_CH-1:0]            busy,
  output logic                         sound
);

  localparam int MIX_BITS = PHASE_BITS + $clog2(NUM_CH);
  localparam int TC_W     = $clog2(TICK_DIV);

  logic [TC_W-1:0]       tick_cnt_q, tick_cnt_d;
  logic                  tick;
  logic [PHASE_BITS-1:0] amp [NUM_CH];
  logic [MIX_BITS-1:0]   mix;
  logic [MIX_BITS-1:0]   mix_q;
  logic [MIX_BITS-1:0]   pwm_cnt_q;
  logic                  sound_q;

  assign tick       = (tick_cnt_q == TC_W'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TC_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_voice
    apu_voice #(
      .PHASE_BITS(PHASE_BITS),
      .VOL_BITS  (VOL_BITS)
    ) u_voice (
      .clk     (clk),
      .reset   (reset),
      .tick_i  (tick),
      .trig_i  (trig[k]),
      .period_i(cfg_period[k*PHASE_BITS +: PHASE_BITS]),
      .wave_i  (cfg_wave[k]),
      .amp_o   (amp[k]),
      .busy_o  (busy[k])
    );
  end

  // Each amp is below 2**PHASE_BITS, so the sum cannot overflow MIX_BITS.
  always_comb begin
    mix = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      mix = mix + MIX_BITS'(amp[k]);
    end
  end

  // Duty is reloaded only on the last count so a PWM period is never torn.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q <= '0;
      mix_q     <= '0;
      sound_q   <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + MIX_BITS'(1);
      if (pwm_cnt_q == '1) begin
        mix_q <= mix;
      end
      sound_q <= (pwm_cnt_q < mix_q);
    end
  end

  assign sound = sound_q;

endmodule

// File: tb/tb_apu_voice_mixer.sv
// tb/tb_apu_voice_mixer.sv - directed self-checking bench for apu_voice_mixer
module tb_apu_voice_mixer;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  trig;
  logic [23:0] cfg_period;
  logic [2:0]  cfg_wave;
  logic [2:0]  busy;
  logic        sound;

  int errors = 0;
  int checks = 0;
  int tcnt   = 0;
  int pcnt   = 0;

  always #5 clk = ~clk;

  apu_voice_mixer #(
    .NUM_CH    (3),
    .PHASE_BITS(8),
    .VOL_BITS  (4),
    .TICK_DIV  (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .trig      (trig),
    .cfg_period(cfg_period),
    .cfg_wave  (cfg_wave),
    .busy      (busy),
    .sound     (sound)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Bench-side copies of the tick and PWM counters, taken just after each edge.
  task automatic step();
    logic r;
    r = reset;
    @(posedge clk);
    #1;
    if (r) begin
      tcnt = 0;
      pcnt = 0;
    end else begin
      tcnt = (tcnt + 1) % 16;
      pcnt = (pcnt + 1) % 1024;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    trig  = 3'b000;
    step();
    step();
    reset = 1'b0;
  endtask

  int quiet, busy_cnt, sound_hi, w, changes, bad, pre;
  logic fell, dropped;
  logic [9:0] old_mixq;

  initial begin
    // reset with random inputs
    reset      = 1'b1;
    trig       = 3'($urandom);
    cfg_period = 24'($urandom);
    cfg_wave   = 3'($urandom);
    repeat (3) begin
      step();
      trig = 3'($urandom);
    end
    check("rst_busy", busy, 0);
    check("rst_sound", sound, 0);
    check("rst_mixq", dut.mix_q, 0);
    check("rst_tickcnt", dut.tick_cnt_q, 0);
    trig  = 3'b000;
    reset = 1'b0;
    quiet = 0;
    repeat (2048) begin
      step();
      if (sound) quiet++;
    end
    check("rst_quiet", quiet, 0);

    // single saw voice, started so a PWM boundary falls mid-play
    cfg_period = {8'd0, 8'd0, 8'd1};
    cfg_wave   = 3'b000;
    for (int i = 0; i < 1024 && pcnt != 899; i++) step();
    trig = 3'b001;
    step();
    check("saw_busy", busy[0], 1);
    check("saw_vol", dut.g_voice[0].u_voice.vol_q, 15);
    check("saw_ph0", dut.g_voice[0].u_voice.phase_q, 0);
    trig = 3'b000;
    step();
    check("saw_ph1", dut.g_voice[0].u_voice.phase_q, 1);
    step();
    check("saw_ph2", dut.g_voice[0].u_voice.phase_q, 2);
    busy_cnt = 3;
    fell     = 1'b0;
    sound_hi = 0;
    for (int k = 3; k <= 1148; k++) begin
      step();
      if (busy[0] && !fell) busy_cnt++;
      else fell = 1'b1;
      if (k == 124) check("saw_mixq", dut.mix_q, 61);
      if (k >= 125 && sound) sound_hi++;
    end
    check("saw_busy_len", busy_cnt, 236);
    check("saw_pwm_high", sound_hi, 61);

    // square voice at full scale, then reset mid-play with a competing start
    do_reset();
    cfg_period = {8'd0, 8'd128, 8'd0};
    cfg_wave   = 3'b010;
    trig       = 3'b010;
    step();
    check("sq_vol", dut.g_voice[1].u_voice.vol_q, 15);
    check("sq_amp0", dut.g_voice[1].u_voice.amp_o, 0);
    trig = 3'b000;
    for (int k = 1; k <= 31; k++) begin
      step();
      if (k == 1) check("sq_amp1", dut.g_voice[1].u_voice.amp_o, 239);
      if (k == 2) check("sq_amp2", dut.g_voice[1].u_voice.amp_o, 0);
      if (k == 15) begin
        check("sq_vol14", dut.g_voice[1].u_voice.vol_q, 14);
        check("sq_amp14", dut.g_voice[1].u_voice.amp_o, 223);
      end
      if (k == 31) check("sq_amp13", dut.g_voice[1].u_voice.amp_o, 207);
    end
    reset = 1'b1;
    trig  = 3'b001;
    step();
    check("midrst_busy", busy, 0);
    check("midrst_sound", sound, 0);
    check("midrst_amp", dut.g_voice[1].u_voice.amp_o, 0);
    trig = 3'b000;
    step();
    reset = 1'b0;

    // retrigger at vol 5
    cfg_period = {8'd0, 8'd0, 8'd1};
    cfg_wave   = 3'b000;
    trig       = 3'b001;
    step();
    trig    = 3'b000;
    w       = 0;
    dropped = 1'b0;
    for (int i = 0; i < 400 && dut.g_voice[0].u_voice.vol_q != 4'd5; i++) begin
      step();
      w++;
      if (!busy[0]) dropped = 1'b1;
    end
    check("retrig_wait", w, 159);
    trig = 3'b001;
    step();
    check("retrig_vol", dut.g_voice[0].u_voice.vol_q, 15);
    check("retrig_ph", dut.g_voice[0].u_voice.phase_q, 0);
    check("retrig_busy", busy[0], 1);
    check("retrig_nodrop", dropped, 0);

    // start edge coincident with a tick
    trig = 3'b000;
    step();
    for (int i = 0; i < 16 && tcnt != 15; i++) step();
    check("coll_tick", dut.tick, 1);
    trig = 3'b001;
    step();
    check("coll_vol", dut.g_voice[0].u_voice.vol_q, 15);
    check("coll_ph", dut.g_voice[0].u_voice.phase_q, 0);
    check("coll_tickcnt", dut.tick_cnt_q, 0);

    // three saw voices, trig held high throughout
    do_reset();
    cfg_period = {8'd3, 8'd2, 8'd1};
    cfg_wave   = 3'b000;
    for (int i = 0; i < 1024 && pcnt != 899; i++) step();
    trig = 3'b111;
    step();
    changes = 0;
    bad     = 0;
    for (int k = 1; k <= 1200; k++) begin
      old_mixq = dut.mix_q;
      pre      = pcnt;
      step();
      if (dut.mix_q != old_mixq) begin
        changes++;
        if (pre != 1023) bad++;
      end
      if (k == 10) check("tri_mix10", dut.mix, 55);
      if (k == 100) begin
        check("tri_mix100", dut.mix, 192);
        check("tri_busy100", busy, 7);
        check("tri_ph100", dut.g_voice[0].u_voice.phase_q, 100);
      end
      if (k == 124) check("tri_mixq", dut.mix_q, 240);
      if (k == 235) check("tri_busy235", busy, 7);
      if (k == 236) check("tri_busy236", busy, 0);
    end
    check("tri_mixq_changes", changes, 2);
    check("tri_mixq_offbound", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
